// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the byte requesters, the scheduler and the tx_unit.
// The master side is the surrounding system (requesters and tx_unit); the slave side is the scheduler.
interface uart_tx_sched_if #(
    parameter int NREQ  = 4,
    parameter int DIV_W = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                en;
    logic [DIV_W-1:0]    divisor;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_ready;
    logic                tx_load;
    logic [7:0]          tx_data;
    logic                tx_en;
    logic                tx_ts;
    logic                busy;
    logic [IDW-1:0]      grant_id;

    modport master (
        output en, divisor, req_valid, req_data, tx_ts,
        input  req_ready, tx_load, tx_data, tx_en, busy, grant_id
    );

    modport slave (
        input  en, divisor, req_valid, req_data, tx_ts,
        output req_ready, tx_load, tx_data, tx_en, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler for one shared tx_unit, with a free-running baud tick generator.
// state      | meaning
// IDLE       | may grant a requester when en, tx_ts and any valid
// LOAD       | tx_load pulse to tx_unit
// WAIT_START | waiting for tx_unit to report busy (tx_ts low)
// WAIT_DONE  | frame in flight, waiting for tx_ts high
module uart_tx_sched #(
    parameter int NREQ  = 4,
    parameter int DIV_W = 16
) (
    input logic              clk,
    input logic              rst,
    uart_tx_sched_if.slave   bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   idx;
    logic             found;
    logic [7:0]       win_data;
    logic             accept;
    logic [7:0]       data_q;
    logic [IDW-1:0]   gid_q;
    logic             load_q;
    logic             tick_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload;

    // Upward scan starting just after the last winner, so the last winner ranks lowest.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) win_data = bus.req_data[8*i +: 8];
        end
    end

    assign accept        = (state == IDLE) && bus.en && bus.tx_ts && found && rst;
    assign bus.req_ready = accept ? (NREQ'(1) << win) : '0;
    assign bus.busy      = (state != IDLE) || !bus.tx_ts;
    assign bus.tx_load   = load_q;
    assign bus.tx_data   = data_q;
    assign bus.grant_id  = gid_q;
    assign bus.tx_en     = tick_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= IDW'(NREQ - 1);
            data_q <= 8'h00;
            gid_q  <= '0;
            load_q <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q <= win_data;
                        gid_q  <= win;
                        ptr    <= win;
                        load_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD:       state <= WAIT_START;
                WAIT_START: if (!bus.tx_ts) state <= WAIT_DONE;
                WAIT_DONE:  if (bus.tx_ts) state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

    // Divisor 0 behaves like 1; the value is only sampled when the counter reloads.
    assign reload = (bus.divisor == '0) ? '0 : bus.divisor - DIV_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= reload;
            tick_q <= 1'b0;
        end else begin
            tick_q <= bus.en && (cnt == '0);
            if (!bus.en || cnt == '0) cnt <= reload;
            else                      cnt <= cnt - DIV_W'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised bench for uart_tx_sched: frame-level reference model, tx_unit model and byte scoreboard.
module tb_uart_tx_sched;
    localparam int NREQ  = 4;
    localparam int DIV_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_tx_sched_if #(.NREQ(NREQ), .DIV_W(DIV_W)) bus ();
    uart_tx_sched #(.NREQ(NREQ), .DIV_W(DIV_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester side: one byte queue per requester, front byte is presented.
    logic [7:0] src_q [NREQ][$];
    logic       acc_any = 1'b0;
    int         acc_w   = 0;

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]       = (src_q[i].size() > 0);
            bus.req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (acc_any && src_q[acc_w].size() > 0) void'(src_q[acc_w].pop_front());
        apply();
    endtask

    task automatic push(input int r, input logic [7:0] b);
        src_q[r].push_back(b);
        apply();
    endtask

    task automatic flush();
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        apply();
    endtask

    // Reference model: frame-level view of the scheduler and the baud tick.
    logic       blocked = 1'b0;
    logic       saw_low = 1'b0;
    int         ptr_m   = NREQ - 1;
    logic       exp_load = 1'b0;
    logic [7:0] exp_data = 8'h00;
    int         exp_gid  = 0;
    logic       exp_ten  = 1'b0;
    int         since    = 0;
    int         period   = 1;
    logic [7:0] exp_q [$];
    int         glog [$];
    int         n_acc = 0;

    always @(negedge clk) begin
        int w;
        int i;
        logic [NREQ-1:0] er;
        if (!rst) begin
            blocked  = 1'b0;
            saw_low  = 1'b0;
            ptr_m    = NREQ - 1;
            exp_load = 1'b0;
            exp_data = 8'h00;
            exp_gid  = 0;
            exp_ten  = 1'b0;
            since    = 0;
            period   = (bus.divisor == 0) ? 1 : int'(bus.divisor);
            acc_any  = 1'b0;
            exp_q.delete();
        end else begin
            w = -1;
            if (!blocked && bus.en && bus.tx_ts) begin
                for (int k = 1; k <= NREQ; k++) begin
                    i = (ptr_m + k) % NREQ;
                    if (w < 0 && bus.req_valid[i]) w = i;
                end
            end
            er = (w >= 0) ? (NREQ'(1) << w) : '0;
            check("req_ready", 32'(bus.req_ready), 32'(er));
            check("tx_load", 32'(bus.tx_load), 32'(exp_load));
            check("tx_data", 32'(bus.tx_data), 32'(exp_data));
            check("grant_id", 32'(bus.grant_id), 32'(exp_gid));
            check("tx_en", 32'(bus.tx_en), 32'(exp_ten));
            check("busy", 32'(bus.busy), 32'(blocked || !bus.tx_ts));

            exp_load = (w >= 0);
            acc_any  = (w >= 0);
            acc_w    = (w >= 0) ? w : 0;
            if (w >= 0) begin
                exp_data = bus.req_data[8*w +: 8];
                exp_gid  = w;
                ptr_m    = w;
                blocked  = 1'b1;
                saw_low  = 1'b0;
                exp_q.push_back(exp_data);
                glog.push_back(w);
                n_acc++;
            end else if (blocked) begin
                if (!bus.tx_ts)  saw_low = 1'b1;
                else if (saw_low) blocked = 1'b0;
            end

            if (!bus.en) begin
                since   = 0;
                period  = (bus.divisor == 0) ? 1 : int'(bus.divisor);
                exp_ten = 1'b0;
            end else begin
                since++;
                if (since >= period) begin
                    exp_ten = 1'b1;
                    since   = 0;
                    period  = (bus.divisor == 0) ? 1 : int'(bus.divisor);
                end else begin
                    exp_ten = 1'b0;
                end
            end
        end
    end

    // tx_unit model: start bit, 8 data bits LSB first, stop bit; idle again on the 11th tick.
    logic       u_busy = 1'b0;
    int         u_ticks = 0;
    logic [9:0] u_shift = '0;
    logic [9:0] u_rec = '0;
    logic [9:0] last_frame = '0;
    int         cyc = 0;
    int         last_tick = 0;
    int         tick_gap = 0;
    int         n_frames = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_busy  = 1'b0;
            u_ticks = 0;
            bus.tx_ts <= 1'b1;
        end else begin
            cyc++;
            if (bus.tx_en) begin
                tick_gap  = cyc - last_tick;
                last_tick = cyc;
            end
            if (u_busy) begin
                check("load_while_busy", 32'(bus.tx_load), 32'(0));
                if (bus.tx_en) begin
                    u_ticks++;
                    if (u_ticks <= 10) begin
                        u_rec[u_ticks-1] = u_shift[0];
                        u_shift = {1'b1, u_shift[9:1]};
                    end
                    if (u_ticks == 11) begin
                        last_frame = u_rec;
                        n_frames++;
                        check("start_stop", 32'({u_rec[9], u_rec[0]}), 32'(2'b10));
                        check("frame_expected", 32'(exp_q.size() != 0), 32'(1));
                        if (exp_q.size() != 0) check("frame_byte", 32'(u_rec[8:1]), 32'(exp_q.pop_front()));
                        u_busy = 1'b0;
                        bus.tx_ts <= 1'b1;
                    end
                end
            end else if (bus.tx_load) begin
                u_busy  = 1'b1;
                u_ticks = 0;
                u_shift = {1'b1, bus.tx_data, 1'b0};
                bus.tx_ts <= 1'b0;
            end
        end
    end

    function automatic bit src_empty();
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_quiet(input string name, input int budget);
        int c = 0;
        while (c < budget && !(src_empty() && !blocked && bus.tx_ts === 1'b1 && exp_q.size() == 0)) begin
            step();
            c++;
        end
        check(name, 32'(c < budget), 32'(1));
    endtask

    task automatic wait_ts_low(input string name);
        int c = 0;
        while (c < 200 && bus.tx_ts !== 1'b0) begin
            step();
            c++;
        end
        check(name, 32'(c < 200), 32'(1));
    endtask

    initial begin
        int n0;
        int base;
        int r;
        bus.en      = 1'b0;
        bus.divisor = DIV_W'(4);
        flush();
        repeat (3) step();

        // Reset values, with a requester already valid.
        push(1, 8'h77);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'(0));
        check("rst_load", 32'(bus.tx_load), 32'(0));
        check("rst_ten", 32'(bus.tx_en), 32'(0));
        check("rst_data", 32'(bus.tx_data), 32'(0));
        check("rst_gid", 32'(bus.grant_id), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        flush();
        bus.en = 1'b1;
        rst    = 1'b1;

        // Single byte 0xA5 at divisor 4.
        n0 = n_acc;
        push(0, 8'hA5);
        wait_quiet("t1_done", 500);
        check("t1_accepts", 32'(n_acc - n0), 32'(1));
        check("t1_frame", 32'(last_frame), 32'(10'h34A));
        check("t1_tick_gap", 32'(tick_gap), 32'(4));

        // All requesters continuously valid; last grant was 0, so order starts at 1.
        bus.divisor = DIV_W'(1);
        base = glog.size();
        for (int i = 0; i < NREQ; i++) begin
            push(i, 8'(8'h10 + i));
            push(i, 8'(8'h20 + i));
        end
        wait_quiet("t2_done", 2000);
        check("t2_count", 32'(glog.size() - base), 32'(8));
        for (int k = 0; k < 8; k++) check("t2_order", 32'(glog[base+k]), 32'((k + 1) % 4));

        // req2 arrives mid-frame and is held until the scheduler is idle again.
        base = glog.size();
        push(0, 8'h31);
        wait_ts_low("t3_start");
        push(2, 8'h32);
        wait_quiet("t3_done", 1000);
        check("t3_count", 32'(glog.size() - base), 32'(2));
        check("t3_first", 32'(glog[base]), 32'(0));
        check("t3_second", 32'(glog[base+1]), 32'(2));

        // Divisor sweep and a mid-count change.
        bus.divisor = DIV_W'(0);
        repeat (10) step();
        check("t4_div0_gap", 32'(tick_gap), 32'(1));
        bus.divisor = DIV_W'(3);
        repeat (12) step();
        check("t4_div3_gap", 32'(tick_gap), 32'(3));
        step();
        bus.divisor = DIV_W'(7);
        repeat (20) step();
        check("t4_div7_gap", 32'(tick_gap), 32'(7));

        // en dropped mid-frame: stall, no new grant, then resume.
        bus.divisor = DIV_W'(2);
        push(1, 8'h5C);
        wait_ts_low("t5_start");
        repeat (4) step();
        bus.en = 1'b0;
        push(3, 8'h66);
        n0 = n_acc;
        repeat (20) step();
        check("t5_no_grant", 32'(n_acc - n0), 32'(0));
        check("t5_stalled", 32'(bus.tx_ts), 32'(0));
        bus.en = 1'b1;
        wait_quiet("t5_done", 1000);
        check("t5_resumed", 32'(n_acc - n0), 32'(1));
        check("t5_last", 32'(glog[glog.size()-1]), 32'(3));

        // Reset during WAIT_DONE, then ptr must favour requester 0 over 3.
        push(2, 8'h99);
        wait_ts_low("t6_start");
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("t6_load", 32'(bus.tx_load), 32'(0));
        check("t6_ten", 32'(bus.tx_en), 32'(0));
        check("t6_data", 32'(bus.tx_data), 32'(0));
        check("t6_gid", 32'(bus.grant_id), 32'(0));
        check("t6_busy", 32'(bus.busy), 32'(0));
        flush();
        step();
        push(0, 8'hC0);
        push(3, 8'hC3);
        #1;
        check("t6_ready_in_rst", 32'(bus.req_ready), 32'(0));
        step();
        rst = 1'b1;
        base = glog.size();
        wait_quiet("t6_done", 1000);
        check("t6_count", 32'(glog.size() - base), 32'(2));
        check("t6_first", 32'(glog[base]), 32'(0));
        check("t6_second", 32'(glog[base+1]), 32'(3));

        // Randomised traffic, en toggling and divisor changes.
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, NREQ - 1));
                if (src_q[r].size() < 3) push(r, 8'($urandom));
            end
            if (bus.en && $urandom_range(0, 63) == 0) bus.en = 1'b0;
            else if (!bus.en && $urandom_range(0, 7) == 0) bus.en = 1'b1;
            if ($urandom_range(0, 99) == 0) bus.divisor = DIV_W'($urandom_range(0, 3));
        end
        bus.en = 1'b1;
        wait_quiet("rand_drain", 5000);
        check("rand_sb_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
